// File: rtl/loop_ctrl_seq.sv
// Start-up and fault sequencer for the regulation loop: precharge, soft-start
// ramp of the reference code, tracking regulation, and fault retry/latch.
module loop_ctrl_seq #(
  parameter int CODE_W    = 6,
  parameter int STEP_DIV  = 4,
  parameter int PRE_CYC   = 16,
  parameter int COOL_CYC  = 32,
  parameter int RETRY_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              flt_ov,
  input  logic              flt_oc,
  input  logic              flt_uv,
  output logic              pre_en,
  output logic              loop_en,
  output logic [CODE_W-1:0] ref_code,
  output logic              pgood,
  output logic [1:0]        fault_code,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_PRE = 3'd1, S_SOFT = 3'd2,
    S_REG = 3'd3, S_FAULT = 3'd4, S_LATCH = 3'd5
  } state_t;

  localparam int TMAX = (PRE_CYC > STEP_DIV) ? PRE_CYC : STEP_DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(COOL_CYC + 1);
  localparam int RW   = $clog2(RETRY_MAX + 2);

  localparam logic [TW-1:0]     PRE_LAST  = TW'(PRE_CYC - 1);
  localparam logic [TW-1:0]     STEP_LAST = TW'(STEP_DIV - 1);
  localparam logic [CW-1:0]     COOL_LAST = CW'(COOL_CYC - 1);
  localparam logic [RW-1:0]     RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [CODE_W-1:0] REF_MAX   = '1;

  // Supply/ground/substrate pins carry no logic.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  state_t            state_reg, state_next;
  logic [TW-1:0]     tmr_reg, tmr_next;
  logic [CW-1:0]     cool_reg, cool_next;
  logic [RW-1:0]     retry_reg, retry_next;
  logic [CODE_W-1:0] ref_reg, ref_next;
  logic [1:0]        fc_reg, fc_next;
  logic              pre_en_reg, pre_en_next;
  logic              loop_en_reg, loop_en_next;
  logic              pgood_reg, pgood_next;

  logic       any_flt;
  logic [1:0] flt_code;
  logic       step_due;

  assign any_flt  = flt_ov | flt_oc | flt_uv;
  assign flt_code = flt_ov ? 2'd1 : (flt_oc ? 2'd2 : 2'd3);
  assign step_due = (tmr_reg == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_OFF;
      tmr_reg     <= '0;
      cool_reg    <= '0;
      retry_reg   <= '0;
      ref_reg     <= '0;
      fc_reg      <= 2'd0;
      pre_en_reg  <= 1'b0;
      loop_en_reg <= 1'b0;
      pgood_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmr_reg     <= tmr_next;
      cool_reg    <= cool_next;
      retry_reg   <= retry_next;
      ref_reg     <= ref_next;
      fc_reg      <= fc_next;
      pre_en_reg  <= pre_en_next;
      loop_en_reg <= loop_en_next;
      pgood_reg   <= pgood_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    cool_next  = cool_reg;
    retry_next = retry_reg;
    ref_next   = ref_reg;
    fc_next    = fc_reg;
    // Dropping en wins over everything, including a fault on the same edge.
    if (state_reg != S_OFF && !en) begin
      state_next = S_OFF;
      tmr_next   = '0;
      cool_next  = '0;
      ref_next   = '0;
    end else if ((state_reg == S_PRE || state_reg == S_SOFT || state_reg == S_REG) && any_flt) begin
      state_next = S_FAULT;
      tmr_next   = '0;
      cool_next  = '0;
      ref_next   = '0;
      fc_next    = flt_code;
    end else begin
      case (state_reg)
        S_OFF: begin
          ref_next = '0;
          if (en) begin
            state_next = S_PRE;
            tmr_next   = '0;
            fc_next    = 2'd0;
            retry_next = '0;
          end
        end
        S_PRE: begin
          if (tmr_reg == PRE_LAST) begin
            state_next = S_SOFT;
            tmr_next   = '0;
            ref_next   = '0;
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
        end
        S_SOFT: begin
          if (step_due) begin
            tmr_next = '0;
            if (ref_reg != REF_MAX) ref_next = ref_reg + CODE_W'(1);
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
          if (ref_next == tgt_code) begin
            state_next = S_REG;
            tmr_next   = '0;
          end
        end
        S_REG: begin
          // The step timer idles at zero while on target.
          if (ref_reg == tgt_code) begin
            tmr_next = '0;
          end else if (step_due) begin
            tmr_next = '0;
            ref_next = (ref_reg < tgt_code) ? ref_reg + CODE_W'(1) : ref_reg - CODE_W'(1);
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
        end
        S_FAULT: begin
          if (any_flt) begin
            cool_next = '0;
          end else if (cool_reg == COOL_LAST) begin
            cool_next = '0;
            tmr_next  = '0;
            if (retry_reg < RETRY_LIM) begin
              state_next = S_PRE;
              retry_next = retry_reg + RW'(1);
            end else begin
              state_next = S_LATCH;
            end
          end else begin
            cool_next = cool_reg + CW'(1);
          end
        end
        S_LATCH: ;
        default: begin
          state_next = S_OFF;
          tmr_next   = '0;
          cool_next  = '0;
          ref_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pre_en_next  = (state_next == S_PRE);
    loop_en_next = (state_next == S_SOFT) || (state_next == S_REG);
    pgood_next   = (state_next == S_REG) && (ref_next == tgt_code);
  end

  assign pre_en     = pre_en_reg;
  assign loop_en    = loop_en_reg;
  assign ref_code   = ref_reg;
  assign pgood      = pgood_reg;
  assign fault_code = fc_reg;
  assign state      = state_reg;

endmodule

// File: doc/loop_ctrl_seq.md
Name: loop_ctrl_seq

Overview:
- Synchronous start-up and fault sequencer for the LOOP/CONTROL regulation loop.
- Orders precharge, soft-start ramp of the loop reference code, and steady regulation.
- Arbitrates three fault inputs; a NOR3 of these inputs is the loop's "all clear" term.
- Drives loop enable, precharge enable, reference code and power-good to the loop datapath.

Parameters:
- CODE_W, 6, width of reference code (ref_code, tgt_code).
- STEP_DIV, 4, cycles per ±1 ref_code step (≥1).
- PRE_CYC, 16, precharge duration in cycles (≥1).
- COOL_CYC, 32, consecutive fault-free cycles required to leave FAULT (≥1).
- RETRY_MAX, 3, auto-restarts allowed before LATCH (≥0).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- CELV  input  1  supply pin; no functional effect.
- CELG  input  1  ground pin; no functional effect.
- SUB  input  1  substrate pin; no functional effect.
- en  input  1  loop enable request.
- tgt_code  input  CODE_W  target reference code.
- flt_ov  input  1  overvoltage fault.
- flt_oc  input  1  overcurrent fault.
- flt_uv  input  1  undervoltage fault.
- pre_en  output  1  precharge enable.
- loop_en  output  1  loop enable.
- ref_code  output  CODE_W  loop reference code.
- pgood  output  1  power good.
- fault_code  output  2  latched fault: 0 none, 1 ov, 2 oc, 3 uv.
- state  output  3  state: OFF=0, PRE=1, SOFT=2, REG=3, FAULT=4, LATCH=5.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=OFF.
  - All outputs 0; all internal counters 0.
  - Reset mid-operation aborts the sequence on that edge.
- All outputs are registered. Inputs sampled at edge N take effect in outputs at edge N.
- any_flt = flt_ov|flt_oc|flt_uv.
- Fault priority: ov > oc > uv.
- OFF:
  - Outputs are 0 except fault_code, which holds its prior value.
  - Faults are ignored.
  - en=1 -> PRE: fault_code cleared, retry_cnt cleared.
- PRE:
  - pre_en=1.
  - After exactly PRE_CYC cycles in PRE -> SOFT.
- SOFT:
  - pre_en=0, loop_en=1.
  - ref_code starts at 0 and increments by 1 every STEP_DIV cycles.
  - Enter REG in the cycle ref_code==tgt_code, including tgt_code=0, which enters REG on the first SOFT cycle.
- REG:
  - loop_en=1.
  - ref_code steps ±1 toward tgt_code every STEP_DIV cycles; it never overshoots or wraps.
  - pgood=1 iff ref_code==tgt_code.
- Fault in PRE/SOFT/REG -> FAULT on the same edge:
  - pre_en, loop_en, pgood and ref_code forced to 0.
  - fault_code latched by priority.
- FAULT:
  - The cooldown counter restarts on any cycle with any_flt=1.
  - After COOL_CYC consecutive clear cycles:
    - retry_cnt<RETRY_MAX -> PRE, retry_cnt++, fault_code held.
    - Otherwise -> LATCH.
  - RETRY_MAX=0 means the first fault goes to LATCH.
- LATCH:
  - Outputs are 0 except fault_code, which holds.
  - Left only via en=0 -> OFF.
- en=0 in any non-OFF state -> OFF on the next edge. This takes priority over a simultaneous fault; fault_code keeps its current value.
- Step and PRE timers restart on every state entry. ref_code arithmetic is saturating within [0, 2^CODE_W-1].

Test Plan:
- Normal start: rst, then en=1 with tgt_code=5 (STEP_DIV=4, PRE_CYC=16).
  - pre_en=1 for 16 cycles.
  - ref_code reaches 5 after 20 SOFT cycles.
  - state=REG, pgood=1.
- Tracking: in REG, change tgt_code 5->3.
  - ref_code gives 4 then 3 at 4-cycle spacing.
  - pgood=0 until ref_code=3.
- Fault and retry: flt_oc pulsed for 1 cycle in REG.
  - FAULT with fault_code=2 and ref_code=0.
  - After 32 clear cycles: PRE, then REG again.
- Simultaneous faults plus continued fault: flt_ov and flt_uv together.
  - fault_code=1.
  - Holding flt_uv in FAULT for 10 cycles delays exit to 42 cycles after entry.
- Retry exhaustion: 4 OC faults, each during SOFT.
  - After the 4th fault, state=LATCH.
  - en=0 -> OFF.
  - en=1 -> PRE with fault_code=0.
- Priority and reset:
  - en=0 with flt_ov in the same cycle -> OFF, fault_code unchanged.
  - rst asserted in SOFT -> all outputs 0 and state=OFF on that edge.
